// File: rtl/rob_tag_sched.sv
// ROB tag scheduler: hands out tags at dispatch, tracks writeback completion,
// retires up to two entries per cycle in order and frees stale RAT mappings.
module rob_tag_sched #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             disp_wr,
  output logic             disp_ready,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  output logic             rat_write,
  output logic [TAG_W-1:0] rat_dest,
  output logic [TAG_W-1:0] rat_tag,
  output logic             free,
  output logic             free2,
  output logic [TAG_W-1:0] tag_done,
  output logic [TAG_W-1:0] tag_done2,
  output logic [1:0]       commit_cnt,
  output logic             rat_clear
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, done_q, wr_q;
  logic [TAG_W-1:0] dest_q   [DEPTH];
  logic [TAG_W-1:0] last_tag [DEPTH];
  logic [TAG_W-1:0] head, tail, head1;
  logic [TAG_W:0]   count;

  logic             fire, disp_wr_eff;
  logic             ret0, ret1, free0_n, free1_n;
  logic [TAG_W-1:0] dest0, dest1;
  logic [1:0]       ncommit;

  assign disp_ready  = (count < FULL_CNT);
  assign disp_tag    = tail;
  assign fire        = disp_valid & disp_ready & ~flush;
  assign disp_wr_eff = disp_wr & (disp_dest != '0);
  assign rat_write   = fire & disp_wr_eff;
  assign rat_dest    = disp_dest;
  assign rat_tag     = tail;

  assign head1   = head + TAG_W'(1);
  assign dest0   = dest_q[head];
  assign dest1   = dest_q[head1];
  assign ret0    = valid_q[head] & done_q[head];
  assign ret1    = ret0 & valid_q[head1] & done_q[head1];
  assign ncommit = {1'b0, ret0} + {1'b0, ret1};

  // A retiring mapping is freed only if nothing younger has since renamed that dest
  assign free0_n = ret0 & wr_q[head] & (last_tag[dest0] == head)
                 & ~(ret1 & wr_q[head1] & (dest1 == dest0))
                 & ~(rat_write & (disp_dest == dest0));
  assign free1_n = ret1 & wr_q[head1] & (last_tag[dest1] == head1)
                 & ~(rat_write & (disp_dest == dest1));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      free       <= 1'b0;
      free2      <= 1'b0;
      tag_done   <= '0;
      tag_done2  <= '0;
      commit_cnt <= '0;
      rat_clear  <= ~rst & flush;
      for (int r = 0; r < DEPTH; r++) last_tag[r] <= TAG_W'(r);
    end else begin
      rat_clear <= 1'b0;
      if (wb_valid && valid_q[wb_tag]) done_q[wb_tag] <= 1'b1;
      if (ret0) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
      end
      if (ret1) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end
      if (free0_n) last_tag[dest0] <= dest0;
      if (free1_n) last_tag[dest1] <= dest1;
      // Dispatch comes last so a same-cycle rename overrides any identity restore
      if (fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        if (disp_wr_eff) last_tag[disp_dest] <= tail;
      end
      head       <= head + TAG_W'(ncommit);
      tail       <= tail + TAG_W'(fire);
      count      <= count + (TAG_W+1)'(fire) - (TAG_W+1)'(ncommit);
      free       <= free0_n;
      free2      <= free1_n;
      tag_done   <= free0_n ? dest0 : '0;
      tag_done2  <= free1_n ? dest1 : '0;
      commit_cnt <= ncommit;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      dest_q[tail] <= disp_dest;
      wr_q[tail]   <= disp_wr_eff;
    end
  end

endmodule
